// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Byte-addressable, little-endian data store answering the CPU datapath's
// load/store requests. A request is taken through a valid/ready handshake,
// waits WAIT_CYCLES cycles, and then gets a single-cycle response pulse.
// Loads return byte/halfword/word data with sign or zero extension; stores
// only touch the addressed bytes (sb/sh/sw). Misaligned or illegal-size
// requests take the full latency, write nothing and return rdata 0 with
// rsp_error set.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset       asynchronous active-low reset (clears FSM, outputs, store)
//   req_valid   request present
//   req_ready   high while idle (combinational decode of the FSM state)
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed  loads only: 1 = sign-extend, 0 = zero-extend
//   req_addr    byte address
//   req_wdata   store data; byte/half use the low 8/16 bits
//   rsp_valid   one-cycle response pulse (loads and stores)
//   rsp_rdata   registered load result, 0 for stores and errors
//   rsp_error   registered misaligned/illegal-size flag
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int         LAST_CNT = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
    localparam logic [3:0] CNT_LAST = LAST_CNT[3:0];

    logic [1:0]           state_q,  state_d;
    logic [3:0]           cnt_q,    cnt_d;
    logic                 we_q,     we_d;
    logic [1:0]           size_q,   size_d;
    logic                 signed_q, signed_d;
    logic [ADDR_W-1:0]    addr_q,   addr_d;
    logic [31:0]          wdata_q,  wdata_d;
    logic [31:0]          rdata_q,  rdata_d;
    logic                 error_q,  error_d;

    // The store is a flat packed vector so the reset clear and the byte-lane
    // updates stay simple whole-vector operations.
    logic [8*DEPTH-1:0]   mem_q,    mem_d;

    logic                 accept;
    logic                 enter_resp;
    logic                 acc_we;
    logic [1:0]           acc_size;
    logic                 acc_signed;
    logic [ADDR_W-1:0]    acc_addr;
    logic [31:0]          acc_wdata;
    logic                 acc_error;
    logic [ADDR_W-1:0]    lane_addr [4];
    logic [7:0]           lane_rdata [4];
    logic [3:0]           byte_we;
    logic [31:0]          load_data;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;
    assign accept    = req_valid & req_ready;

    // The access acts on the registered request, except when WAIT_CYCLES is
    // zero: then the response is committed on the acceptance edge itself and
    // the request fields are still only on the inputs.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we     = req_we;
            acc_size   = req_size;
            acc_signed = req_signed;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_we     = we_q;
            acc_size   = size_q;
            acc_signed = signed_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
        end
    end

    // Edge on which the FSM moves into RESP: the store is committed and the
    // response registers are loaded on this edge.
    always_comb begin
        enter_resp = 1'b0;
        if (state_q == ST_IDLE) begin
            enter_resp = accept && (WAIT_CYCLES == 0);
        end else if (state_q == ST_WAIT) begin
            enter_resp = (cnt_q == CNT_LAST);
        end
    end

    // Illegal size, or a halfword/word not naturally aligned.
    always_comb begin
        acc_error = 1'b0;
        case (acc_size)
            2'b01:   acc_error = acc_addr[0];
            2'b10:   acc_error = (acc_addr[1:0] != 2'b00);
            2'b11:   acc_error = 1'b1;
            default: acc_error = 1'b0;
        endcase
    end

    // Byte lanes a..a+3; aligned accesses never run past the top of the store.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k]  = acc_addr + ADDR_W'(k);
            lane_rdata[k] = mem_q[{lane_addr[k], 3'b000} +: 8];
        end
    end

    // Little-endian assembly with optional sign extension; word loads ignore
    // the signed flag.
    always_comb begin
        load_data = 32'h0;
        case (acc_size)
            2'b00:   load_data = {{24{acc_signed & lane_rdata[0][7]}}, lane_rdata[0]};
            2'b01:   load_data = {{16{acc_signed & lane_rdata[1][7]}}, lane_rdata[1], lane_rdata[0]};
            2'b10:   load_data = {lane_rdata[3], lane_rdata[2], lane_rdata[1], lane_rdata[0]};
            default: load_data = 32'h0;
        endcase
    end

    // Only legal stores write, and only on the edge that raises rsp_valid.
    always_comb begin
        byte_we = 4'b0000;
        if (enter_resp && acc_we && !acc_error) begin
            case (acc_size)
                2'b00:   byte_we = 4'b0001;
                2'b01:   byte_we = 4'b0011;
                2'b10:   byte_we = 4'b1111;
                default: byte_we = 4'b0000;
            endcase
        end
        mem_d = mem_q;
        for (int k = 0; k < 4; k++) begin
            if (byte_we[k]) begin
                mem_d[{lane_addr[k], 3'b000} +: 8] = acc_wdata[8*k +: 8];
            end
        end
    end

    // FSM, request capture and response registers. rdata/error default to
    // zero so they are only non-zero during the RESP cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = 32'h0;
        error_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = 4'd0;
                    state_d  = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            error_d = acc_error;
            if (!acc_error && !acc_we) begin
                rdata_d = load_data;
            end
        end
    end

    // Reset drops any pending request: no response and no write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
            mem_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. u_dut uses WAIT_CYCLES = 2 and carries
// most of the sequence; u_dut0 uses WAIT_CYCLES = 0 for the zero-wait
// back-to-back case. Inputs change 1 ns after a rising edge and outputs are
// sampled at that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    logic        z_req_valid;
    logic        z_req_ready;
    logic        z_req_we;
    logic [1:0]  z_req_size;
    logic        z_req_signed;
    logic [7:0]  z_req_addr;
    logic [31:0] z_req_wdata;
    logic        z_rsp_valid;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_we     (z_req_we),
        .req_size   (z_req_size),
        .req_signed (z_req_signed),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .rsp_valid  (z_rsp_valid),
        .rsp_rdata  (z_rsp_rdata),
        .rsp_error  (z_rsp_error)
    );

    // One comparison: count it, and on a miss count and report it.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request to u_dut while it is idle and let it be accepted,
    // then scramble the request inputs, which must now be ignored.
    task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [7:0] addr, input logic [31:0] wdata);
        check_output("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = 2'b11;
        req_signed = ~sgn;
        req_addr   = 8'hFF;
        req_wdata  = 32'hA5A5A5A5;
    endtask

    // Wait (bounded) for the response pulse, check latency and payload, then
    // check that the pulse and the payload drop back to zero one cycle later.
    task automatic wait_response(input string tag, input logic [31:0] exp_rdata,
                                 input logic exp_err);
        int lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check_output({tag, "_lat"}, 32'(lat), 32'd2);
        check_output({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check_output({tag, "_err"}, {31'b0, rsp_error}, {31'b0, exp_err});
        step();
        check_output({tag, "_vclr"}, {30'b0, rsp_valid, rsp_error}, 32'd0);
        check_output({tag, "_dclr"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [6:0] exp_ready7;
        logic [6:0] exp_valid7;
        logic [3:0] exp_ready4;
        logic [3:0] exp_valid4;

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_signed   = 1'b0;
        req_addr     = 8'h00;
        req_wdata    = 32'h0;
        z_req_valid  = 1'b0;
        z_req_we     = 1'b0;
        z_req_size   = 2'b00;
        z_req_signed = 1'b0;
        z_req_addr   = 8'h00;
        z_req_wdata  = 32'h0;

        // Reset values while reset is held low.
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check_output("rst_rdata", rsp_rdata, 32'd0);
        check_output("rst_error", {31'b0, rsp_error}, 32'd0);
        reset = 1'b1;
        step();
        check_output("post_rst_ready", {31'b0, req_ready}, 32'd1);
        check_output("post_rst_valid", {31'b0, rsp_valid}, 32'd0);

        // Cleared store reads zero.
        apply_stimulus(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
        wait_response("lw_10", 32'h00000000, 1'b0);

        // Word store then loads of every width.
        apply_stimulus(1'b1, 2'b10, 1'b0, 8'h20, 32'hDEADBEEF);
        wait_response("sw_20", 32'h00000000, 1'b0);
        apply_stimulus(1'b0, 2'b10, 1'b0, 8'h20, 32'h0);
        wait_response("lw_20", 32'hDEADBEEF, 1'b0);
        apply_stimulus(1'b0, 2'b00, 1'b0, 8'h20, 32'h0);
        wait_response("lbu_20", 32'h000000EF, 1'b0);
        apply_stimulus(1'b0, 2'b00, 1'b0, 8'h23, 32'h0);
        wait_response("lbu_23", 32'h000000DE, 1'b0);
        apply_stimulus(1'b0, 2'b00, 1'b1, 8'h20, 32'h0);
        wait_response("lb_20", 32'hFFFFFFEF, 1'b0);
        apply_stimulus(1'b0, 2'b00, 1'b1, 8'h23, 32'h0);
        wait_response("lb_23", 32'hFFFFFFDE, 1'b0);

        // Byte store merges into the existing word.
        apply_stimulus(1'b1, 2'b00, 1'b0, 8'h21, 32'hFFFFFF5A);
        wait_response("sb_21", 32'h00000000, 1'b0);
        apply_stimulus(1'b0, 2'b10, 1'b0, 8'h20, 32'h0);
        wait_response("lw_20b", 32'hDEAD5AEF, 1'b0);
        apply_stimulus(1'b0, 2'b01, 1'b0, 8'h22, 32'h0);
        wait_response("lhu_22", 32'h0000DEAD, 1'b0);
        apply_stimulus(1'b0, 2'b01, 1'b1, 8'h22, 32'h0);
        wait_response("lh_22", 32'hFFFFDEAD, 1'b0);

        // Error cases: flagged, rdata 0, nothing written.
        apply_stimulus(1'b1, 2'b01, 1'b0, 8'h21, 32'h00001111);
        wait_response("sh_21_err", 32'h00000000, 1'b1);
        apply_stimulus(1'b0, 2'b10, 1'b0, 8'h22, 32'h0);
        wait_response("lw_22_err", 32'h00000000, 1'b1);
        apply_stimulus(1'b0, 2'b11, 1'b0, 8'h20, 32'h0);
        wait_response("l11_err", 32'h00000000, 1'b1);
        apply_stimulus(1'b1, 2'b11, 1'b0, 8'h20, 32'h00000000);
        wait_response("s11_err", 32'h00000000, 1'b1);
        apply_stimulus(1'b0, 2'b10, 1'b0, 8'h20, 32'h0);
        wait_response("lw_20_keep", 32'hDEAD5AEF, 1'b0);

        // Back-to-back with req_valid held: half store 0xBEEF to 0x30, then a
        // signed half load of 0x30. Index i is the sample after edge t+i,
        // where t is the first acceptance edge.
        exp_ready7 = 7'b0001000;
        exp_valid7 = 7'b1000100;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b01;
        req_signed = 1'b0;
        req_addr   = 8'h30;
        req_wdata  = 32'h0000BEEF;
        step();
        req_we     = 1'b0;
        req_signed = 1'b1;
        req_wdata  = 32'h0;
        for (int i = 0; i < 7; i++) begin
            check_output($sformatf("b2b_ready_%0d", i), {31'b0, req_ready}, {31'b0, exp_ready7[i]});
            check_output($sformatf("b2b_valid_%0d", i), {31'b0, rsp_valid}, {31'b0, exp_valid7[i]});
            if (i == 2) begin
                check_output("b2b_st_rdata", rsp_rdata, 32'h0);
            end
            if (i == 4) begin
                req_valid = 1'b0;
            end
            if (i == 6) begin
                check_output("b2b_ld_rdata", rsp_rdata, 32'hFFFFBEEF);
                check_output("b2b_ld_err", {31'b0, rsp_error}, 32'd0);
            end
            step();
        end
        check_output("b2b_ready_end", {31'b0, req_ready}, 32'd1);

        // Zero wait states: each response arrives one edge after acceptance.
        exp_ready4   = 4'b1010;
        exp_valid4   = 4'b0101;
        check_output("z_ready_idle", {31'b0, z_req_ready}, 32'd1);
        z_req_valid  = 1'b1;
        z_req_we     = 1'b1;
        z_req_size   = 2'b10;
        z_req_addr   = 8'h08;
        z_req_wdata  = 32'hCAFEF00D;
        step();
        z_req_we     = 1'b0;
        z_req_wdata  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("z_ready_%0d", i), {31'b0, z_req_ready}, {31'b0, exp_ready4[i]});
            check_output($sformatf("z_valid_%0d", i), {31'b0, z_rsp_valid}, {31'b0, exp_valid4[i]});
            if (i == 0) begin
                check_output("z_st_rdata", z_rsp_rdata, 32'h0);
            end
            if (i == 2) begin
                check_output("z_ld_rdata", z_rsp_rdata, 32'hCAFEF00D);
                z_req_valid = 1'b0;
            end
            if (i == 3) begin
                check_output("z_ld_clr", z_rsp_rdata, 32'h0);
            end
            step();
        end

        // Reset during WAIT of a word store: dropped, no pulse, no write.
        apply_stimulus(1'b1, 2'b10, 1'b0, 8'h40, 32'h12345678);
        step();
        check_output("rw_wait_valid", {31'b0, rsp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("rw_hold_valid_%0d", i), {31'b0, rsp_valid}, 32'd0);
            check_output($sformatf("rw_hold_rdata_%0d", i), rsp_rdata, 32'd0);
            check_output($sformatf("rw_hold_ready_%0d", i), {31'b0, req_ready}, 32'd1);
            step();
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_output($sformatf("rw_no_rsp_%0d", i), {31'b0, rsp_valid}, 32'd0);
        end
        apply_stimulus(1'b0, 2'b10, 1'b0, 8'h40, 32'h0);
        wait_response("lw_40_after_rst", 32'h00000000, 1'b0);
        apply_stimulus(1'b0, 2'b10, 1'b0, 8'h20, 32'h0);
        wait_response("lw_20_cleared", 32'h00000000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
